uart_bridge_ctrl: RTL and testbench

UART_BRIDGE_CTRL -- requirements
Module: uart_bridge_ctrl

---
 rtl/uart_bridge_ctrl.sv | 179 +++++++++++++++++
 tb/tb_uart_bridge_ctrl.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_bridge_ctrl.sv
// uart_bridge_ctrl: turns framed UART byte packets into single register-bus
// read/write transactions. Packet: SYNC, CMD, [DATA_HI, DATA_LO], CHK, where
// CHK is the XOR of CMD and any data bytes. Errors (checksum, inter-byte
// timeout, byte dropped while busy) are flagged with a one-cycle err pulse.
module uart_bridge_ctrl #(
  parameter int         DATA_LEN     = 8,
  parameter logic [7:0] SYNC_BYTE    = 8'hA5,
  parameter int         TIMEOUT_CLKS = 26040
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                rx_valid,
  input  logic [DATA_LEN-1:0] rx_byte,
  output logic                bus_req,
  output logic                bus_we,
  output logic [6:0]          bus_addr,
  output logic [15:0]         bus_wdata,
  input  logic                bus_ack,
  input  logic [15:0]         bus_rdata,
  output logic                done,
  output logic [15:0]         rd_data,
  output logic                err,
  output logic [1:0]          err_code,
  output logic                busy
);

  localparam int CNT_W = $clog2(TIMEOUT_CLKS + 1);

  localparam logic [1:0] ERR_CHK  = 2'b01;
  localparam logic [1:0] ERR_TOUT = 2'b10;
  localparam logic [1:0] ERR_DROP = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CMD   = 3'd1,
    S_DHI   = 3'd2,
    S_DLO   = 3'd3,
    S_CHK   = 3'd4,
    S_ISSUE = 3'd5,
    S_DONE  = 3'd6
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic             r_we;
  logic [6:0]       r_addr;
  logic [15:0]      r_wdata;
  logic [7:0]       r_chk;
  logic [CNT_W-1:0] r_tcnt;
  logic [15:0]      r_rd_data;
  logic             r_err;
  logic [1:0]       r_err_code;

  logic [7:0]       w_byte;
  logic             w_in_pkt;
  logic             w_tout_hit;
  logic             w_tout;
  logic             w_chk_bad;
  logic             w_drop;

  assign w_byte     = rx_byte[7:0];
  assign w_in_pkt   = (r_state == S_CMD) || (r_state == S_DHI) ||
                      (r_state == S_DLO) || (r_state == S_CHK);
  assign w_tout_hit = (r_tcnt == CNT_W'(TIMEOUT_CLKS - 1));

  // State register; reset abandons any packet or pending transaction.
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state decode plus the per-cycle error events it produces.
  always_comb begin
    w_next    = r_state;
    w_tout    = 1'b0;
    w_chk_bad = 1'b0;
    w_drop    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (rx_valid && (w_byte == SYNC_BYTE)) w_next = S_CMD;
      end
      S_CMD: begin
        if (rx_valid)        w_next = w_byte[7] ? S_DHI : S_CHK;
        else if (w_tout_hit) begin w_tout = 1'b1; w_next = S_IDLE; end
      end
      S_DHI: begin
        if (rx_valid)        w_next = S_DLO;
        else if (w_tout_hit) begin w_tout = 1'b1; w_next = S_IDLE; end
      end
      S_DLO: begin
        if (rx_valid)        w_next = S_CHK;
        else if (w_tout_hit) begin w_tout = 1'b1; w_next = S_IDLE; end
      end
      S_CHK: begin
        if (rx_valid) begin
          if (w_byte == r_chk) w_next = S_ISSUE;
          else begin w_chk_bad = 1'b1; w_next = S_IDLE; end
        end else if (w_tout_hit) begin
          w_tout = 1'b1;
          w_next = S_IDLE;
        end
      end
      S_ISSUE: begin
        w_drop = rx_valid;
        if (bus_ack) w_next = S_DONE;
      end
      S_DONE: begin
        w_drop = rx_valid;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Command/data capture and running XOR checksum while a packet is parsed.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_chk   <= '0;
    end else if (rx_valid) begin
      case (r_state)
        S_IDLE: if (w_byte == SYNC_BYTE) r_chk <= '0;
        S_CMD: begin
          r_we   <= w_byte[7];
          r_addr <= w_byte[6:0];
          r_chk  <= r_chk ^ w_byte;
        end
        S_DHI: begin
          r_wdata[15:8] <= w_byte;
          r_chk         <= r_chk ^ w_byte;
        end
        S_DLO: begin
          r_wdata[7:0] <= w_byte;
          r_chk        <= r_chk ^ w_byte;
        end
        default: ;
      endcase
    end
  end

  // Inter-byte idle counter: runs only mid-packet, cleared by any byte.
  always_ff @(posedge clk) begin
    if (reset)                              r_tcnt <= '0;
    else if (w_in_pkt && !rx_valid && !w_tout) r_tcnt <= r_tcnt + 1'b1;
    else                                    r_tcnt <= '0;
  end

  // Read data capture on the acknowledging cycle of a read.
  always_ff @(posedge clk) begin
    if (reset)                                        r_rd_data <= '0;
    else if ((r_state == S_ISSUE) && bus_ack && !r_we) r_rd_data <= bus_rdata;
  end

  // Error pulse and sticky error code.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_err      <= 1'b0;
      r_err_code <= '0;
    end else begin
      r_err <= w_chk_bad | w_tout | w_drop;
      if (w_chk_bad)   r_err_code <= ERR_CHK;
      else if (w_tout) r_err_code <= ERR_TOUT;
      else if (w_drop) r_err_code <= ERR_DROP;
    end
  end

  assign bus_req   = (r_state == S_ISSUE);
  assign bus_we    = r_we;
  assign bus_addr  = r_addr;
  assign bus_wdata = r_wdata;
  assign done      = (r_state == S_DONE);
  assign rd_data   = r_rd_data;
  assign err       = r_err;
  assign err_code  = r_err_code;
  assign busy      = (r_state == S_ISSUE) || (r_state == S_DONE);

endmodule

// File: tb/tb_uart_bridge_ctrl.sv
// Directed bench for uart_bridge_ctrl with hand-computed expectations.
// A short timeout is used so the idle-expiry cases run quickly.
module tb_uart_bridge_ctrl;

  localparam int TOUT = 40;

  logic        clk = 1'b0;
  logic        reset;
  logic        rx_valid;
  logic [7:0]  rx_byte;
  logic        bus_req;
  logic        bus_we;
  logic [6:0]  bus_addr;
  logic [15:0] bus_wdata;
  logic        bus_ack;
  logic [15:0] bus_rdata;
  logic        done;
  logic [15:0] rd_data;
  logic        err;
  logic [1:0]  err_code;
  logic        busy;

  int n_vec = 0;
  int n_bad = 0;

  uart_bridge_ctrl #(
    .DATA_LEN    (8),
    .SYNC_BYTE   (8'hA5),
    .TIMEOUT_CLKS(TOUT)
  ) u_dut (
    .clk      (clk),
    .reset    (reset),
    .rx_valid (rx_valid),
    .rx_byte  (rx_byte),
    .bus_req  (bus_req),
    .bus_we   (bus_we),
    .bus_addr (bus_addr),
    .bus_wdata(bus_wdata),
    .bus_ack  (bus_ack),
    .bus_rdata(bus_rdata),
    .done     (done),
    .rd_data  (rd_data),
    .err      (err),
    .err_code (err_code),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // Every comparison in the bench goes through here.
  task automatic check_vec(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_byte  = b;
    tick();
    rx_valid = 1'b0;
    rx_byte  = 8'h00;
  endtask

  task automatic ack(input logic [15:0] rdata);
    bus_ack   = 1'b1;
    bus_rdata = rdata;
    tick();
    bus_ack   = 1'b0;
    bus_rdata = 16'h0000;
  endtask

  function automatic logic [63:0] all_outs();
    return {18'd0, bus_req, bus_we, bus_addr, bus_wdata, done, rd_data, err, err_code, busy};
  endfunction

  initial begin
    reset     = 1'b1;
    rx_valid  = 1'b0;
    rx_byte   = 8'h00;
    bus_ack   = 1'b0;
    bus_rdata = 16'h0000;
    tick();
    tick();
    check_vec("reset_outs", all_outs(), 64'd0);
    reset = 1'b0;
    tick();

    // Write 0x1234 to address 0x05; checksum 85^12^34 = A3.
    send(8'hA5); send(8'h85); send(8'h12);
    check_vec("wr_no_req_early", {63'd0, bus_req}, 64'd0);
    send(8'h34); send(8'hA3);
    check_vec("wr_req", {63'd0, bus_req}, 64'd1);
    check_vec("wr_fields", {39'd0, bus_we, bus_addr, bus_wdata}, {39'd0, 1'b1, 7'h05, 16'h1234});
    check_vec("wr_busy", {63'd0, busy}, 64'd1);
    tick(); tick();
    check_vec("wr_stable", {38'd0, bus_req, bus_we, bus_addr, bus_wdata}, {38'd0, 1'b1, 1'b1, 7'h05, 16'h1234});
    ack(16'hFFFF);
    check_vec("wr_done", {61'd0, done, bus_req, busy}, {61'd0, 3'b101});
    check_vec("wr_rd_untouched", {48'd0, rd_data}, 64'd0);
    tick();
    check_vec("wr_after_done", {61'd0, done, busy, err}, 64'd0);

    // Read from address 0x07; checksum 07.
    send(8'hA5); send(8'h07); send(8'h07);
    check_vec("rd_fields", {55'd0, bus_req, bus_we, bus_addr}, {55'd0, 1'b1, 1'b0, 7'h07});
    ack(16'hBEEF);
    check_vec("rd_done", {63'd0, done}, 64'd1);
    check_vec("rd_data", {48'd0, rd_data}, 64'hBEEF);
    tick();
    check_vec("rd_data_held", {47'd0, done, rd_data}, 64'hBEEF);

    // Bad checksum.
    send(8'hA5); send(8'h85); send(8'h12); send(8'h34); send(8'h00);
    check_vec("chk_err", {60'd0, err, err_code, bus_req}, {60'd0, 1'b1, 2'b01, 1'b0});
    tick();
    check_vec("chk_err_pulse", {60'd0, err, err_code, bus_req}, {60'd0, 1'b0, 2'b01, 1'b0});
    tick();
    check_vec("chk_no_req", {62'd0, bus_req, busy}, 64'd0);

    // Timeout: T idle clocks after a mid-packet byte.
    send(8'hA5); send(8'h85);
    for (int i = 0; i < TOUT - 1; i++) tick();
    check_vec("tout_not_yet", {63'd0, err}, 64'd0);
    tick();
    check_vec("tout_err", {61'd0, err, err_code}, {61'd0, 1'b1, 2'b10});
    tick();
    check_vec("tout_pulse", {63'd0, err}, 64'd0);
    send(8'hA5); send(8'h07); send(8'h07);
    check_vec("tout_recover_req", {63'd0, bus_req}, 64'd1);
    ack(16'h1357);
    check_vec("tout_recover_done", {47'd0, done, rd_data}, {47'd0, 1'b1, 16'h1357});
    tick();

    // A byte arriving on the expiry cycle wins.
    send(8'hA5); send(8'h85);
    for (int i = 0; i < TOUT - 1; i++) tick();
    send(8'h12);
    check_vec("tout_byte_wins", {63'd0, err}, 64'd0);
    send(8'h34); send(8'hA3);
    check_vec("tout_byte_wins_req", {63'd0, bus_req}, 64'd1);
    ack(16'h0000);
    tick();

    // SYNC value as data; chk = 85^A5^00 = 20. Then drop a byte while awaiting ack.
    send(8'hA5); send(8'h85); send(8'hA5); send(8'h00); send(8'h20);
    check_vec("sync_as_data", {39'd0, bus_req, bus_addr, bus_wdata}, {39'd0, 1'b1, 7'h05, 16'hA500});
    send(8'h55);
    check_vec("drop_err", {61'd0, err, err_code}, {61'd0, 1'b1, 2'b11});
    check_vec("drop_bus_same", {38'd0, bus_req, bus_we, bus_addr, bus_wdata}, {38'd0, 1'b1, 1'b1, 7'h05, 16'hA500});
    tick();
    ack(16'h0000);
    check_vec("drop_then_done", {62'd0, done, err}, {62'd0, 1'b1, 1'b0});
    tick();

    // Byte and ack on the same cycle of a read.
    send(8'hA5); send(8'h07); send(8'h07);
    rx_valid = 1'b1; rx_byte = 8'h55;
    ack(16'hCAFE);
    rx_valid = 1'b0;
    check_vec("drop_ack_same", {44'd0, done, err, err_code, rd_data}, {44'd0, 1'b1, 1'b1, 2'b11, 16'hCAFE});
    tick();

    // Reset in DLO.
    send(8'hA5); send(8'h85); send(8'h12);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_vec("rst_in_dlo", all_outs(), 64'd0);
    tick();
    check_vec("rst_dlo_quiet", {62'd0, done, err}, 64'd0);

    // Reset in ISSUE.
    send(8'hA5); send(8'h85); send(8'h12); send(8'h34); send(8'hA3);
    check_vec("pre_rst_req", {63'd0, bus_req}, 64'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_vec("rst_in_issue", all_outs(), 64'd0);
    ack(16'h0000);
    check_vec("ack_outside_issue", {61'd0, done, err, bus_req}, 64'd0);

    // Garbage bytes in IDLE.
    send(8'h00);
    send(8'hFF);
    tick();
    check_vec("garbage_ignored", {61'd0, err, busy, bus_req}, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
